// File: rtl/prefetch_stream_buffer_if.sv
// Lookup/result bus between the L1 miss path (master) and the stream prefetch buffer (slave).
interface prefetch_stream_buffer_if #(
    parameter int ADDR_W = 32
);
    logic              lookup_req;
    logic [ADDR_W-1:0] lookup_addr;
    logic              lookup_ready;
    logic              result_valid;
    logic              prefetch_hit;
    logic [19:0]       hit_count;
    logic [19:0]       miss_count;

    modport master (
        output lookup_req, lookup_addr,
        input  lookup_ready, result_valid, prefetch_hit, hit_count, miss_count
    );

    modport slave (
        input  lookup_req, lookup_addr,
        output lookup_ready, result_valid, prefetch_hit, hit_count, miss_count
    );
endinterface

// File: rtl/prefetch_stream_buffer.sv
// Next-line stream prefetch buffer holding block addresses beside the L1 cache.
// Optional PF_FLUSH_EN adds a flush input that clears the buffer and forces IDLE.
module prefetch_stream_buffer #(
    parameter int ADDR_W    = 32,
    parameter int OFFSET_W  = 4,
    parameter int DEPTH     = 4,
    parameter int PF_DEGREE = 2
) (
    input  logic clk,
    input  logic reset,
`ifdef PF_FLUSH_EN
    input  logic flush,
`endif
    prefetch_stream_buffer_if.slave bus
);
    localparam int BLK_W = ADDR_W - OFFSET_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int K_W   = $clog2(PF_DEGREE + 1);

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL} state_t;

    function automatic logic [19:0] sat_inc(input logic [19:0] v);
        return (v == 20'hFFFFF) ? v : v + 20'd1;
    endfunction

    state_t           state_q, state_d;
    logic [BLK_W-1:0] blk_q;
    logic [BLK_W-1:0] cand;
    logic [BLK_W-1:0] cmp_blk;
    logic [BLK_W-1:0] entry_blk [DEPTH];
    logic [DEPTH-1:0] entry_vld;
    logic [DEPTH-1:0] match;
    logic [PTR_W-1:0] wr_ptr;
    logic [K_W-1:0]   k_q;
    logic             result_valid_q;
    logic             prefetch_hit_q;
    logic [19:0]      hit_count_q;
    logic [19:0]      miss_count_q;
    logic             flush_i;
    logic             accept;
    logic             unused_offset_bits;

`ifdef PF_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    assign unused_offset_bits = ^bus.lookup_addr[OFFSET_W-1:0];

    // Block-address addition wraps naturally at BLK_W bits
    assign cand    = blk_q + BLK_W'(k_q);
    assign cmp_blk = (state_q == LOOKUP) ? blk_q : cand;

    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = entry_vld[i] && (entry_blk[i] == cmp_blk);
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.lookup_req) begin
                        state_d = LOOKUP;
                        accept  = 1'b1;
                    end
                end
                LOOKUP:  state_d = FILL;
                FILL:    if (k_q == K_W'(PF_DEGREE)) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            entry_vld      <= '0;
            wr_ptr         <= '0;
            k_q            <= '0;
            result_valid_q <= 1'b0;
            prefetch_hit_q <= 1'b0;
            hit_count_q    <= '0;
            miss_count_q   <= '0;
        end else begin
            result_valid_q <= 1'b0;
            if (flush_i) begin
                entry_vld <= '0;
                wr_ptr    <= '0;
            end else begin
                case (state_q)
                    IDLE: if (accept) prefetch_hit_q <= 1'b0;
                    LOOKUP: begin
                        // A hit block migrates into L1, so its entry is dropped
                        result_valid_q <= 1'b1;
                        prefetch_hit_q <= |match;
                        entry_vld      <= entry_vld & ~match;
                        if (|match) hit_count_q  <= sat_inc(hit_count_q);
                        else        miss_count_q <= sat_inc(miss_count_q);
                        k_q            <= K_W'(1);
                    end
                    FILL: begin
                        if (!(|match)) begin
                            entry_vld[wr_ptr] <= 1'b1;
                            wr_ptr            <= wr_ptr + 1'b1;
                        end
                        k_q <= k_q + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Address storage carries no reset; validity lives in entry_vld
    always_ff @(posedge clk) begin
        if (accept) blk_q <= bus.lookup_addr[ADDR_W-1:OFFSET_W];
        if (state_q == FILL && !(|match)) entry_blk[wr_ptr] <= cand;
    end

    assign bus.lookup_ready = (state_q == IDLE);
    assign bus.result_valid = result_valid_q;
    assign bus.prefetch_hit = prefetch_hit_q;
    assign bus.hit_count    = hit_count_q;
    assign bus.miss_count   = miss_count_q;
endmodule

// File: tb/tb_prefetch_stream_buffer.sv
// Directed bench for prefetch_stream_buffer with a transaction-level buffer model checked every cycle.
`timescale 1ns/1ps
module tb_prefetch_stream_buffer;
    localparam int ADDR_W    = 32;
    localparam int OFFSET_W  = 4;
    localparam int DEPTH     = 4;
    localparam int PF_DEGREE = 2;
    localparam int BLK_W     = ADDR_W - OFFSET_W;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    prefetch_stream_buffer_if #(.ADDR_W(ADDR_W)) bus ();

    prefetch_stream_buffer #(
        .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .DEPTH(DEPTH), .PF_DEGREE(PF_DEGREE)
    ) dut (
        .clk   (clk),
        .reset (reset),
`ifdef PF_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] sat20(input logic [19:0] v);
        return (v == 20'hFFFFF) ? v : v + 20'd1;
    endfunction

    // Model: a lookup is resolved as a whole transaction at acceptance;
    // its visible result appears one edge later, and the block stays busy
    // for 1+PF_DEGREE edges.
    logic [BLK_W-1:0] m_blk [DEPTH];
    bit               m_vld [DEPTH];
    int               m_ptr      = 0;
    int               m_busy     = 0;
    bit               m_pend     = 0;
    bit               m_pend_hit = 0;
    bit               m_rv       = 0;
    bit               m_hit      = 0;
    bit               started    = 0;
    logic [19:0]      m_hc       = '0;
    logic [19:0]      m_mc       = '0;

    task automatic model_accept(input logic [BLK_W-1:0] b);
        logic [BLK_W-1:0] c;
        bit dup;
        m_pend_hit = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_vld[i] && m_blk[i] == b) begin
                m_pend_hit = 1;
                m_vld[i]   = 0;
            end
        end
        for (int k = 1; k <= PF_DEGREE; k++) begin
            c   = b + BLK_W'(k);
            dup = 0;
            for (int i = 0; i < DEPTH; i++) if (m_vld[i] && m_blk[i] == c) dup = 1;
            if (!dup) begin
                m_blk[m_ptr] = c;
                m_vld[m_ptr] = 1;
                m_ptr        = (m_ptr + 1) % DEPTH;
            end
        end
        m_hit  = 0;
        m_pend = 1;
        m_busy = 1 + PF_DEGREE;
    endtask

    always @(posedge clk) begin
        started = 1;
        m_rv    = 0;
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin m_vld[i] = 0; m_blk[i] = '0; end
            m_ptr = 0; m_busy = 0; m_pend = 0; m_hit = 0; m_hc = '0; m_mc = '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
            m_ptr = 0; m_busy = 0; m_pend = 0;
        end else begin
            if (m_pend) begin
                m_rv  = 1;
                m_hit = m_pend_hit;
                if (m_pend_hit) m_hc = sat20(m_hc);
                else            m_mc = sat20(m_mc);
                m_pend = 0;
            end
            if (m_busy > 0) m_busy--;
            else if (bus.lookup_req) model_accept(bus.lookup_addr[ADDR_W-1:OFFSET_W]);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("lookup_ready", bus.lookup_ready, (m_busy == 0));
            chk("result_valid", bus.result_valid, m_rv);
            chk("prefetch_hit", bus.prefetch_hit, m_hit);
            chk("hit_count",    bus.hit_count,    m_hc);
            chk("miss_count",   bus.miss_count,   m_mc);
        end
    end

    // Called at a negedge; returns the hit flag and edges from accept until ready.
    task automatic do_lookup(input logic [31:0] addr, output bit hit, output int lat);
        int t;
        t = 0;
        while (!bus.lookup_ready && t < 20) begin @(negedge clk); t++; end
        chk("ready_before_lookup", bus.lookup_ready, 1);
        bus.lookup_addr = addr;
        bus.lookup_req  = 1'b1;
        @(negedge clk);
        bus.lookup_req  = 1'b0;
        lat = 0;
        t   = 0;
        while (!bus.result_valid && t < 10) begin @(negedge clk); lat++; t++; end
        chk("result_arrives", bus.result_valid, 1);
        hit = bus.prefetch_hit;
        while (!bus.lookup_ready && t < 20) begin @(negedge clk); lat++; t++; end
        chk("ready_returns", bus.lookup_ready, 1);
    endtask

    initial begin
        bit h;
        int lat;
        int pulses;
        bus.lookup_req  = 1'b0;
        bus.lookup_addr = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", bus.lookup_ready, 1);
        chk("rst_hit_count", bus.hit_count, 0);
        chk("rst_miss_count", bus.miss_count, 0);

        do_lookup(32'h0000_1000, h, lat);
        chk("cold_hit", h, 0);
        chk("cold_miss_count", bus.miss_count, 1);
        chk("cold_latency", lat, 3);
        do_lookup(32'h0000_1010, h, lat);
        chk("stream_hit", h, 1);
        chk("stream_hit_count", bus.hit_count, 1);
        do_lookup(32'h0000_1020, h, lat);
        chk("skip_kept_102", h, 1);

        do_lookup(32'h0000_5000, h, lat);
        do_lookup(32'h0000_6000, h, lat);
        do_lookup(32'h0000_1030, h, lat);
        chk("evicted_103_miss", h, 0);
        chk("evict_miss_count", bus.miss_count, 4);
        do_lookup(32'h0000_6010, h, lat);
        chk("rr_601_hit", h, 1);

        do_lookup(32'hFFFF_FFF0, h, lat);
        chk("wrap_first_miss", h, 0);
        do_lookup(32'h0000_0000, h, lat);
        chk("wrap_second_hit", h, 1);
        chk("wrap_hit_count", bus.hit_count, 4);

        @(posedge clk); #2;
        force dut.hit_count_q = 20'hFFFFE;
        m_hc = 20'hFFFFE;
        @(posedge clk); #2;
        release dut.hit_count_q;
        @(negedge clk);
        do_lookup(32'h0000_0010, h, lat);
        chk("sat_reach", bus.hit_count, 32'hFFFFF);
        do_lookup(32'h0000_0020, h, lat);
        chk("sat_hold_hit", h, 1);
        chk("sat_hold", bus.hit_count, 32'hFFFFF);

        bus.lookup_addr = 32'h0000_2000;
        bus.lookup_req  = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.result_valid) pulses++;
        end
        bus.lookup_req = 1'b0;
        chk("busy_accepts", pulses, 2);
        chk("busy_miss_count", bus.miss_count, 7);

        bus.lookup_addr = 32'h0000_3000;
        bus.lookup_req  = 1'b1;
        @(negedge clk);
        bus.lookup_req  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midfill_rst_ready", bus.lookup_ready, 1);
        chk("midfill_rst_valid", bus.result_valid, 0);
        chk("midfill_rst_hit", bus.prefetch_hit, 0);
        chk("midfill_rst_hc", bus.hit_count, 0);
        chk("midfill_rst_mc", bus.miss_count, 0);
        do_lookup(32'h0000_1010, h, lat);
        chk("post_rst_miss", h, 0);
        chk("post_rst_mc", bus.miss_count, 1);

`ifdef PF_FLUSH_EN
        do_lookup(32'h0000_1000, h, lat);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        do_lookup(32'h0000_1010, h, lat);
        chk("flush_then_miss", h, 0);
        chk("flush_mc", bus.miss_count, 3);
        bus.lookup_addr = 32'h0000_1020;
        bus.lookup_req  = 1'b1;
        @(negedge clk);
        bus.lookup_req  = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_no_result", bus.result_valid, 0);
        chk("flush_ready", bus.lookup_ready, 1);
        chk("flush_mc_kept", bus.miss_count, 3);
        bus.lookup_req = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        bus.lookup_req = 1'b0;
        flush = 1'b0;
        chk("flush_blocks_accept", bus.lookup_ready, 1);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
